// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and widths for the decode-to-execute pipeline register.
// Also holds the funct3 constants for the ALU and the branch unit.
package id_ex_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNC_W     = 10;

    typedef enum logic [1:0] {
        ASelRs1  = 2'd0,
        ASelPc   = 2'd1,
        ASelZero = 2'd2,
        ASelRsvd = 2'd3
    } a_sel_e;

    typedef enum logic {
        BSelRs2 = 1'b0,
        BSelImm = 1'b1
    } b_sel_e;

    // ALU funct3 decodes
    localparam logic [2:0] F3_ADD_SUB     = 3'b000;
    localparam logic [2:0] F3_SHIFT_LEFT  = 3'b001;
    localparam logic [2:0] F3_XOR         = 3'b100;
    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;
    localparam logic [2:0] F3_OR          = 3'b110;
    localparam logic [2:0] F3_AND         = 3'b111;

    // Branch funct3 decodes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Two's-complement negation; wraps so the most negative value maps to itself.
    function automatic logic [XLEN-1:0] twos_negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB, x0 never forwards.
// exm_match flags an EX/MEM hit so the parent can detect load-use hazards.
module operand_forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned Width = XLEN,
    parameter int unsigned AddrW = REG_ADDR_W
) (
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] stored_val,
    input  logic             exm_reg_write,
    input  logic [AddrW-1:0] exm_rd_addr,
    input  logic [Width-1:0] exm_result,
    input  logic             wb_reg_write,
    input  logic [AddrW-1:0] wb_rd_addr,
    input  logic [Width-1:0] wb_result,
    output logic [Width-1:0] fwd_val,
    output logic             exm_match
);

    logic addr_nonzero;
    logic wb_match;

    assign addr_nonzero = (addr != '0);
    assign exm_match    = exm_reg_write & (exm_rd_addr == addr) & addr_nonzero;
    assign wb_match     = wb_reg_write & (wb_rd_addr == addr) & addr_nonzero;

    always_comb begin
        fwd_val = stored_val;
        if (exm_match) begin
            fwd_val = exm_result;
        end else if (wb_match) begin
            fwd_val = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: single-entry storage, operand forwarding,
// load-use bubble insertion and SUB negation of operand b.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_val,
    input  logic [XLEN-1:0]       in_rs2_val,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [FUNC_W-1:0]     in_func,
    input  logic [1:0]            in_a_sel,
    input  logic                  in_b_sel,
    input  logic                  in_sub,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic                  in_is_branch,
    input  logic                  in_reg_write,
    input  logic                  exm_reg_write,
    input  logic                  exm_is_load,
    input  logic [REG_ADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]       exm_result,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]       wb_result,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [XLEN-1:0]       alu_bits_a,
    output logic [XLEN-1:0]       alu_bits_b,
    output logic [FUNC_W-1:0]     alu_func,
    output logic [XLEN-1:0]       out_store_data,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
    output logic                  out_is_load,
    output logic                  out_is_store,
    output logic                  out_is_branch
);

    logic                  full_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       rs1_val_q;
    logic [XLEN-1:0]       rs2_val_q;
    logic [XLEN-1:0]       imm_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [FUNC_W-1:0]     func_q;
    a_sel_e                a_sel_q;
    b_sel_e                b_sel_q;
    logic                  sub_q;
    logic                  is_load_q;
    logic                  is_store_q;
    logic                  is_branch_q;
    logic                  reg_write_q;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            rs1_exm_match;
    logic            rs2_exm_match;
    logic            load_use;
    logic            advance;
    logic            capture;
    logic [XLEN-1:0] b_raw;

    operand_forward_mux #(
        .Width(XLEN),
        .AddrW(REG_ADDR_W)
    ) u_fwd_rs1 (
        .addr         (rs1_addr_q),
        .stored_val   (rs1_val_q),
        .exm_reg_write(exm_reg_write),
        .exm_rd_addr  (exm_rd_addr),
        .exm_result   (exm_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .wb_result    (wb_result),
        .fwd_val      (rs1_fwd),
        .exm_match    (rs1_exm_match)
    );

    operand_forward_mux #(
        .Width(XLEN),
        .AddrW(REG_ADDR_W)
    ) u_fwd_rs2 (
        .addr         (rs2_addr_q),
        .stored_val   (rs2_val_q),
        .exm_reg_write(exm_reg_write),
        .exm_rd_addr  (exm_rd_addr),
        .exm_result   (exm_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .wb_result    (wb_result),
        .fwd_val      (rs2_fwd),
        .exm_match    (rs2_exm_match)
    );

    // exm_match already folds in exm_reg_write and the x0 exclusion.
    assign load_use = full_q & exm_is_load &
                      ((rs1_exm_match & (a_sel_q == ASelRs1)) |
                       (rs2_exm_match & ((b_sel_q == BSelRs2) | is_store_q)));

    assign out_valid = full_q & ~load_use & ~flush;
    assign in_ready  = ~full_q | (out_ready & ~load_use);
    assign advance   = out_valid & out_ready;
    assign capture   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 1'b0;
            pc_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            func_q      <= '0;
            a_sel_q     <= ASelRs1;
            b_sel_q     <= BSelRs2;
            sub_q       <= 1'b0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (capture) begin
            full_q      <= 1'b1;
            pc_q        <= in_pc;
            rs1_val_q   <= in_rs1_val;
            rs2_val_q   <= in_rs2_val;
            imm_q       <= in_imm;
            rs1_addr_q  <= in_rs1_addr;
            rs2_addr_q  <= in_rs2_addr;
            rd_addr_q   <= in_rd_addr;
            func_q      <= in_func;
            a_sel_q     <= a_sel_e'(in_a_sel);
            b_sel_q     <= b_sel_e'(in_b_sel);
            sub_q       <= in_sub;
            is_load_q   <= in_is_load;
            is_store_q  <= in_is_store;
            is_branch_q <= in_is_branch;
            reg_write_q <= in_reg_write;
        end else if (advance) begin
            full_q <= 1'b0;
        end else if (full_q) begin
            // Stalled: keep whatever was forwarded so it survives the producer leaving WB.
            rs1_val_q <= rs1_fwd;
            rs2_val_q <= rs2_fwd;
        end
    end

    always_comb begin
        alu_bits_a = '0;
        case (a_sel_q)
            ASelRs1: alu_bits_a = rs1_fwd;
            ASelPc:  alu_bits_a = pc_q;
            default: alu_bits_a = '0;
        endcase
    end

    assign b_raw      = (b_sel_q == BSelImm) ? imm_q : rs2_fwd;
    // Branches compare a - b inside the ALU, so they keep b un-negated.
    assign alu_bits_b = (sub_q & ~is_branch_q) ? twos_negate(b_raw) : b_raw;

    assign alu_func       = func_q;
    assign out_store_data = rs2_fwd;
    assign out_pc         = pc_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_reg_write  = reg_write_q & out_valid;
    assign out_is_load    = is_load_q & out_valid;
    assign out_is_store   = is_store_q & out_valid;
    assign out_is_branch  = is_branch_q & out_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, SUB negation, forwarding priority,
// load-use bubble, stall refresh, flush and reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic [9:0]  in_func;
    logic [1:0]  in_a_sel;
    logic        in_b_sel;
    logic        in_sub;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_branch;
    logic        in_reg_write;
    logic        exm_reg_write;
    logic        exm_is_load;
    logic [4:0]  exm_rd_addr;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] alu_bits_a;
    logic [31:0] alu_bits_b;
    logic [9:0]  alu_func;
    logic [31:0] out_store_data;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_is_branch;

    int vectors;
    int miscompares;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .in_imm        (in_imm),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rd_addr    (in_rd_addr),
        .in_func       (in_func),
        .in_a_sel      (in_a_sel),
        .in_b_sel      (in_b_sel),
        .in_sub        (in_sub),
        .in_is_load    (in_is_load),
        .in_is_store   (in_is_store),
        .in_is_branch  (in_is_branch),
        .in_reg_write  (in_reg_write),
        .exm_reg_write (exm_reg_write),
        .exm_is_load   (exm_is_load),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .alu_bits_a    (alu_bits_a),
        .alu_bits_b    (alu_bits_b),
        .alu_func      (alu_func),
        .out_store_data(out_store_data),
        .out_pc        (out_pc),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write),
        .out_is_load   (out_is_load),
        .out_is_store  (out_is_store),
        .out_is_branch (out_is_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid      = 1'b0;
        in_pc         = '0;
        in_rs1_val    = '0;
        in_rs2_val    = '0;
        in_imm        = '0;
        in_rs1_addr   = '0;
        in_rs2_addr   = '0;
        in_rd_addr    = '0;
        in_func       = '0;
        in_a_sel      = 2'd0;
        in_b_sel      = 1'b0;
        in_sub        = 1'b0;
        in_is_load    = 1'b0;
        in_is_store   = 1'b0;
        in_is_branch  = 1'b0;
        in_reg_write  = 1'b0;
        exm_reg_write = 1'b0;
        exm_is_load   = 1'b0;
        exm_rd_addr   = '0;
        exm_result    = '0;
        wb_reg_write  = 1'b0;
        wb_rd_addr    = '0;
        wb_result     = '0;
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset bits_a", alu_bits_a, 32'd0);
        check("reset bits_b", alu_bits_b, 32'd0);
        check("reset out_pc", out_pc, 32'd0);

        // ADDI x1 = x2 + 5
        in_valid = 1'b1; in_pc = 32'h100; in_rs1_addr = 5'd2; in_rs1_val = 32'd10;
        in_imm = 32'd5; in_b_sel = 1'b1; in_rd_addr = 5'd1; in_reg_write = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("addi out_valid", 32'(out_valid), 32'd1);
        check("addi bits_a", alu_bits_a, 32'd10);
        check("addi bits_b", alu_bits_b, 32'd5);
        check("addi func", 32'(alu_func), 32'h000);
        check("addi rd", 32'(out_rd_addr), 32'd1);
        check("addi reg_write", 32'(out_reg_write), 32'd1);
        check("addi pc", out_pc, 32'h100);

        // SUB 7 - 3, replacing the ADDI on the same edge
        in_valid = 1'b1; in_rs1_addr = 5'd6; in_rs2_addr = 5'd7; in_rs1_val = 32'd7;
        in_rs2_val = 32'd3; in_sub = 1'b1; in_func = 10'h100;
        tick();
        clear_inputs();
        #1;
        check("sub no bubble", 32'(out_valid), 32'd1);
        check("sub bits_a", alu_bits_a, 32'd7);
        check("sub bits_b", alu_bits_b, 32'hFFFF_FFFD);
        check("sub func", 32'(alu_func), 32'h100);

        // SUB with most negative operand
        in_valid = 1'b1; in_rs2_addr = 5'd7; in_rs2_val = 32'h8000_0000; in_sub = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("sub minint bits_b", alu_bits_b, 32'h8000_0000);

        // Branch with sub flag set keeps b un-negated
        in_valid = 1'b1; in_rs2_addr = 5'd7; in_rs2_val = 32'd3; in_sub = 1'b1;
        in_is_branch = 1'b1; in_func = 10'h001;
        tick();
        clear_inputs();
        #1;
        check("branch bits_b", alu_bits_b, 32'd3);
        check("branch flag", 32'(out_is_branch), 32'd1);

        // Forwarding priority on rs1 = x4
        in_valid = 1'b1; in_rs1_addr = 5'd4; in_rs1_val = 32'h99; in_b_sel = 1'b1;
        tick();
        clear_inputs();
        exm_reg_write = 1'b1; exm_rd_addr = 5'd4; exm_result = 32'h11;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'h22;
        #1;
        check("fwd exm priority", alu_bits_a, 32'h11);
        exm_reg_write = 1'b0;
        #1;
        check("fwd wb", alu_bits_a, 32'h22);
        exm_reg_write = 1'b1; exm_rd_addr = 5'd0; wb_rd_addr = 5'd0;
        #1;
        check("fwd rd x0 stored", alu_bits_a, 32'h99);

        // rs1 = x0 is never forwarded
        clear_inputs();
        in_valid = 1'b1; in_rs1_addr = 5'd0; in_rs1_val = 32'h77; in_rs2_addr = 5'd0;
        in_rs2_val = 32'h66;
        tick();
        clear_inputs();
        exm_reg_write = 1'b1; exm_rd_addr = 5'd0; exm_result = 32'h11;
        #1;
        check("x0 rs1 stored", alu_bits_a, 32'h77);
        check("x0 store data", out_store_data, 32'h66);
        clear_inputs();

        // Load-use on x5, then WB forwards the loaded value
        in_valid = 1'b1; in_rs1_addr = 5'd5; in_b_sel = 1'b1;
        tick();
        clear_inputs();
        exm_reg_write = 1'b1; exm_is_load = 1'b1; exm_rd_addr = 5'd5; exm_result = 32'h1234;
        #1;
        check("lu out_valid", 32'(out_valid), 32'd0);
        check("lu in_ready", 32'(in_ready), 32'd0);
        tick();
        clear_inputs();
        wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_result = 32'hAB;
        #1;
        check("lu release out_valid", 32'(out_valid), 32'd1);
        check("lu release bits_a", alu_bits_a, 32'hAB);
        clear_inputs();

        // Stall refresh: WB forwards 0x55 for one cycle only
        in_valid = 1'b1; in_rs1_addr = 5'd3; in_rs1_val = 32'd1; in_b_sel = 1'b1;
        tick();
        clear_inputs();
        out_ready = 1'b0;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_result = 32'h55;
        #1;
        check("refresh cycle1 bits_a", alu_bits_a, 32'h55);
        tick();
        wb_reg_write = 1'b0;
        #1;
        check("refresh cycle2 bits_a", alu_bits_a, 32'h55);
        check("refresh in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        #1;
        check("refresh release valid", 32'(out_valid), 32'd1);
        check("refresh release bits_a", alu_bits_a, 32'h55);
        tick();
        check("retire out_valid", 32'(out_valid), 32'd0);
        check("retire in_ready", 32'(in_ready), 32'd1);

        // Flush while full with a new instruction arriving
        in_valid = 1'b1; in_pc = 32'h300; in_reg_write = 1'b1; in_rd_addr = 5'd8;
        tick();
        out_ready = 1'b0;
        in_pc = 32'h304;
        #1;
        check("preflush out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        #1;
        check("flush cycle out_valid", 32'(out_valid), 32'd0);
        check("flush cycle reg_write", 32'(out_reg_write), 32'd0);
        tick();
        flush = 1'b0;
        clear_inputs();
        #1;
        check("post flush out_valid", 32'(out_valid), 32'd0);
        check("post flush in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a hold
        in_valid = 1'b1; in_pc = 32'h200; in_rs1_addr = 5'd9; in_rs1_val = 32'h33;
        in_imm = 32'h44; in_b_sel = 1'b1; in_rd_addr = 5'd9; in_reg_write = 1'b1;
        in_func = 10'h007;
        tick();
        clear_inputs();
        #1;
        check("hold out_pc", out_pc, 32'h200);
        check("hold bits_b", alu_bits_b, 32'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst bits_a", alu_bits_a, 32'd0);
        check("rst bits_b", alu_bits_b, 32'd0);
        check("rst out_pc", out_pc, 32'd0);
        check("rst func", 32'(alu_func), 32'd0);
        check("rst rd", 32'(out_rd_addr), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU and drives its bits_a, bits_b and func inputs.
- Holds one decoded instruction and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts a bubble.
- Applies the SUB negation, because the ALU's funct3=000 path only adds.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high (one clock domain; polarity and synchronicity fixed)
flush  in  1  discard held and incoming instruction (branch taken / redirect)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
in_pc  in  XLEN  instruction PC
in_rs1_val / in_rs2_val  in  XLEN  register-file read data
in_imm  in  XLEN  sign-extended immediate
in_rs1_addr / in_rs2_addr / in_rd_addr  in  REG_ADDR_W  register indices
in_func  in  10  {funct7, funct3}; bit 8 = funct7[5]
in_a_sel  in  2  0 = rs1, 1 = pc, 2 = zero, 3 = reserved (acts as zero)
in_b_sel  in  1  0 = rs2, 1 = imm
in_sub  in  1  R-type SUB
in_is_load / in_is_store / in_is_branch / in_reg_write  in  1  decode flags
exm_reg_write, exm_is_load  in  1  EX/MEM stage flags
exm_rd_addr  in  REG_ADDR_W  EX/MEM destination
exm_result  in  XLEN  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB write enable
wb_rd_addr  in  REG_ADDR_W  MEM/WB destination
wb_result  in  XLEN  MEM/WB writeback data
out_ready  in  1  execute/downstream can accept
out_valid  out  1  ALU operands valid
alu_bits_a, alu_bits_b  out  XLEN  ALU operands
alu_func  out  10  held in_func, passed unchanged
out_store_data  out  XLEN  forwarded rs2 value
out_pc  out  XLEN  held PC
out_rd_addr  out  REG_ADDR_W  held rd
out_reg_write, out_is_load, out_is_store, out_is_branch  out  1  held flags; forced 0 when out_valid = 0

Behaviour:
- Storage is a single entry with a full flag; every field is registered.
- Reset: full = 0 and all stored fields = 0, so every output reads 0 and in_ready = 1 on the first cycle after reset.
- Forwarding (combinational from stored addresses) for each of rs1 and rs2:
  - If exm_reg_write, exm_rd_addr == addr and addr != 0, use exm_result.
  - Else if wb_reg_write, wb_rd_addr == addr and addr != 0, use wb_result.
  - Else use the stored value.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- Load-use hazard: lu = full & exm_is_load & exm_reg_write & (exm_rd_addr != 0) & match, where match is:
  - (rs1 match and a_sel = 0), or
  - (rs2 match and (b_sel = 0 or is_store)).
- Output handshake:
  - out_valid = full & ~lu & ~flush.
  - in_ready = ~full | (out_ready & ~lu).
  - Advance out = out_valid & out_ready.
- Operand selection:
  - alu_bits_a = forwarded rs1, in_pc or 0 according to a_sel.
  - alu_bits_b = forwarded rs2 or imm according to b_sel.
  - If the stored sub flag is set, alu_bits_b = ~b + 1, computed modulo 2^XLEN (0x8000_0000 maps to itself).
  - Branch instructions never negate; the ALU compares a − b itself.
- Capture: when in_valid & in_ready & ~flush, load all fields next edge and set full = 1.
- Retire: if the entry advances out with no capture in the same cycle, full = 0.
- Simultaneous retire and capture: the entry is replaced on the same edge with no bubble.
- Hold refresh: while full and not advancing (lu or ~out_ready), write the forwarded rs1/rs2 values back into storage each cycle, so data forwarded from MEM/WB is not lost once it leaves MEM/WB.
- Flush:
  - Next edge: full = 0.
  - The incoming instruction in the flush cycle is dropped.
  - out_valid is 0 during the flush cycle.
- Priority order: rst > flush > capture/retire.
- Latency: one cycle from capture to out_valid when no hazard is present.
- A load-use hazard inserts exactly one bubble for a single-cycle MEM stage.

Decomposition:
- Shared package holds:
  - a_sel / b_sel encodings;
  - ALU funct3 constants (ADD_SUB, SHIFT_LEFT/RIGHT, XOR, OR, AND) and branch funct3 constants;
  - XLEN and REG_ADDR_W.
- One sub-module, operand_forward_mux (combinational, instantiated twice for rs1 and rs2).
  - Inputs: addr, stored value and both forward sources.
  - Outputs: the selected value and a match flag, which feeds lu.

Test Plan:
- ADDI x1 = x2 + 5 with in_rs1_val = 10, no hazards → the cycle after capture, out_valid = 1, bits_a = 10, bits_b = 5, func = 0x000.
- SUB with rs1 = 7, rs2 = 3 → bits_b = 0xFFFF_FFFD; with rs2 = 0x8000_0000 → bits_b = 0x8000_0000.
- rs1 = x4 with exm writing x4 = 0x11 and wb writing x4 = 0x22 → bits_a = 0x11; with rd = x0 on both → the stored value is used.
- Load in EX/MEM to x5, held instruction uses x5 → out_valid = 0 and in_ready = 0 for one cycle. Next cycle wb forwards x5 = 0xAB → out_valid = 1, bits_a = 0xAB.
- out_ready held low for 3 cycles while wb forwards 0x55 only in cycle 1 → after release, bits_a = 0x55 (refresh works).
- flush asserted with full = 1 and in_valid = 1 → next cycle full = 0 and out_valid = 0. Assert rst mid-hold → all outputs 0 on the next edge.
